// File: rtl/mac_ctrl_if.sv
// rtl/mac_ctrl_if.sv - job, beat stream and result handshake bundle for mac_ctrl
interface mac_ctrl_if #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int LW      = 8
);
  logic                start;
  logic [LW-1:0]       len;
  logic [PSUM_BW-1:0]  bias;
  logic                in_valid;
  logic                in_ready;
  logic [4*BW-1:0]     a;
  logic [4*BW-1:0]     b;
  logic                out_valid;
  logic                out_ready;
  logic [PSUM_BW-1:0]  out;
  logic                busy;

  modport master (
    output start, len, bias, in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  start, len, bias, in_valid, a, b, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/mac_ctrl.sv
// rtl/mac_ctrl.sv - 4-lane unsigned x signed MAC sequencer with job, beat and result handshakes
module mac_ctrl #(
  parameter int BW      = 4,
  parameter int PSUM_BW = 16,
  parameter int LW      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  mac_ctrl_if.slave   s_if
);

  localparam int PW = 2*BW + 1;
  localparam int DW = 2*BW + 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [PSUM_BW-1:0]  r_acc;
  logic [PSUM_BW-1:0]  w_acc_nxt;
  logic [LW-1:0]       r_cnt;
  logic [LW-1:0]       w_cnt_nxt;
  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_busy;

  logic signed [PW-1:0] w_prod [4];
  logic signed [DW-1:0] w_dot;
  logic [PSUM_BW-1:0]   w_dot_ext;

  // Activation is zero-extended so it stays non-negative in the signed product.
  genvar g;
  for (g = 0; g < 4; g++) begin : g_lane
    assign w_prod[g] = $signed({{(BW+1){1'b0}}, s_if.a[BW*g +: BW]})
                     * $signed({{(BW+1){s_if.b[BW*g+BW-1]}}, s_if.b[BW*g +: BW]});
  end

  assign w_dot     = DW'(w_prod[0]) + DW'(w_prod[1]) + DW'(w_prod[2]) + DW'(w_prod[3]);
  assign w_dot_ext = {{(PSUM_BW-DW){w_dot[DW-1]}}, w_dot};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Handshake outputs depend on r_state only, never on the inbound valid/ready/start.
  always_comb begin
    w_next_state = r_state;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (s_if.start) begin
          w_acc_nxt = s_if.bias;
          if (s_if.len != '0) begin
            w_cnt_nxt    = s_if.len;
            w_next_state = S_RUN;
          end else begin
            w_next_state = S_DONE;
          end
        end
      end
      S_RUN: begin
        w_in_ready = 1'b1;
        if (s_if.in_valid) begin
          w_acc_nxt = r_acc + w_dot_ext;
          w_cnt_nxt = r_cnt - LW'(1);
          if (r_cnt == LW'(1)) begin
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (s_if.out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = w_out_valid;
  assign s_if.busy      = w_busy;
  assign s_if.out       = r_acc;

endmodule
